// File: rtl/snake_dir_input.sv
// Button conditioning and direction arbitration for the snake game core.
// Optional macro DIR_QUEUE2_EN replaces the single pending register with a 2-entry FIFO.
module snake_dir_input #(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned CNT_W      = 19
) (
    input  logic       SYS_CLK,
    input  logic       RST_N,
    input  logic       UP,
    input  logic       DOWN,
    input  logic       LEFT,
    input  logic       RIGHT,
    input  logic       PAUSE,
    input  logic       STEP,
    output logic [1:0] move_dir,
    output logic       dir_changed,
    output logic       paused
);

    localparam int unsigned NB = 5;
    localparam int unsigned ND = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    // Button bit order: 0 up, 1 down, 2 left, 3 right, 4 pause
    logic [NB-1:0]    w_raw;
    logic [NB-1:0]    r_sync1;
    logic [NB-1:0]    r_sync2;
    logic [NB-1:0]    r_stable;
    logic [NB-1:0]    r_stable_d;
    logic [NB-1:0]    w_press;
    logic [CNT_W-1:0] r_cnt [NB];

    logic       w_req_valid;
    logic [1:0] w_req_dir;
    logic [3:0] w_others;
    logic       w_step_act;
    logic       w_pause_tgl;
    logic [1:0] w_ref;
    logic       w_accept;
    logic [1:0] w_move_nxt;
    logic       w_chg_nxt;

    logic [1:0] r_move_dir;
    logic       r_dir_changed;
    logic       r_paused;

    function automatic logic [1:0] opposite(input logic [1:0] d);
        return {d[1], ~d[0]};
    endfunction

    assign w_raw = {PAUSE, RIGHT, LEFT, DOWN, UP};

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Stable level flips only after DEB_CYCLES consecutive disagreeing samples
    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_stable   <= '0;
            r_stable_d <= '0;
            for (int i = 0; i < NB; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_stable_d <= r_stable;
            for (int i = 0; i < NB; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_stable[i] <= ~r_stable[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_press     = r_stable & ~r_stable_d;
    assign w_step_act  = STEP & ~r_paused;
    assign w_pause_tgl = w_press[4];

    // A request needs its own press pulse with every other direction released
    always_comb begin
        w_req_valid = 1'b0;
        w_req_dir   = 2'b00;
        w_others    = 4'b0000;
        for (int i = 0; i < ND; i++) begin
            w_others    = r_stable[3:0];
            w_others[i] = 1'b0;
            if (w_press[i] && (w_others == 4'b0000)) begin
                w_req_valid = 1'b1;
                w_req_dir   = 2'(i);
            end
        end
    end

`ifdef DIR_QUEUE2_EN
    logic [1:0] r_q0;
    logic [1:0] r_q1;
    logic [1:0] r_qcnt;
    logic [1:0] w_q0_nxt;
    logic [1:0] w_q1_nxt;
    logic [1:0] w_qcnt_nxt;
    logic [1:0] w_p_q0;
    logic [1:0] w_p_cnt;
    logic       w_pop;

    // Pop first, then judge the request against the post-pop tail
    always_comb begin
        w_pop      = w_step_act && (r_qcnt != 2'd0);
        w_p_cnt    = w_pop ? (r_qcnt - 2'd1) : r_qcnt;
        w_p_q0     = w_pop ? r_q1 : r_q0;
        w_move_nxt = w_pop ? r_q0 : r_move_dir;
        w_chg_nxt  = w_pop && (r_q0 != r_move_dir);
        case (w_p_cnt)
            2'd0:    w_ref = w_move_nxt;
            2'd1:    w_ref = w_p_q0;
            default: w_ref = r_q1;
        endcase
        w_accept = w_req_valid && !r_paused && (w_req_dir != w_ref)
                   && (w_req_dir != opposite(w_ref)) && (w_p_cnt != 2'd2);
        w_q0_nxt   = w_p_q0;
        w_q1_nxt   = r_q1;
        w_qcnt_nxt = w_p_cnt;
        if (w_accept) begin
            if (w_p_cnt == 2'd0) begin
                w_q0_nxt = w_req_dir;
            end else begin
                w_q1_nxt = w_req_dir;
            end
            w_qcnt_nxt = w_p_cnt + 2'd1;
        end
        if (w_pause_tgl) begin
            w_qcnt_nxt = 2'd0;
        end
    end

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_q0   <= 2'b00;
            r_q1   <= 2'b00;
            r_qcnt <= 2'd0;
        end else begin
            r_q0   <= w_q0_nxt;
            r_q1   <= w_q1_nxt;
            r_qcnt <= w_qcnt_nxt;
        end
    end
`else
    logic [1:0] r_pending;
    logic [1:0] w_pending_nxt;

    always_comb begin
        w_ref         = STEP ? r_pending : r_move_dir;
        w_accept      = w_req_valid && !r_paused && (w_req_dir != opposite(w_ref));
        w_pending_nxt = w_accept ? w_req_dir : r_pending;
        w_move_nxt    = w_step_act ? r_pending : r_move_dir;
        w_chg_nxt     = w_step_act && (r_pending != r_move_dir);
    end

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pending <= 2'b00;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end
`endif

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_move_dir    <= 2'b00;
            r_dir_changed <= 1'b0;
            r_paused      <= 1'b0;
        end else begin
            r_move_dir    <= w_move_nxt;
            r_dir_changed <= w_chg_nxt;
            r_paused      <= r_paused ^ w_pause_tgl;
        end
    end

    assign move_dir    = r_move_dir;
    assign dir_changed = r_dir_changed;
    assign paused      = r_paused;

endmodule

// File: tb/tb_snake_dir_input.sv
// Directed vector bench for snake_dir_input with a short debounce window.
module tb_snake_dir_input;

    localparam int unsigned DEB   = 4;
    localparam int unsigned CNT_W = 3;

    localparam logic [4:0] B_NONE  = 5'b00000;
    localparam logic [4:0] B_UP    = 5'b00001;
    localparam logic [4:0] B_DOWN  = 5'b00010;
    localparam logic [4:0] B_LEFT  = 5'b00100;
    localparam logic [4:0] B_RIGHT = 5'b01000;
    localparam logic [4:0] B_PAUSE = 5'b10000;

    localparam logic [1:0] D_UP    = 2'b00;
    localparam logic [1:0] D_DOWN  = 2'b01;
    localparam logic [1:0] D_LEFT  = 2'b10;
    localparam logic [1:0] D_RIGHT = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       up, down, left, right, pause, step;
    logic [1:0] move_dir;
    logic       dir_changed;
    logic       paused;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0] btn;
        int         hold;
        logic       stp;
        logic [1:0] dir;
        logic       chg;
        logic       p;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    snake_dir_input #(.DEB_CYCLES(DEB), .CNT_W(CNT_W)) dut (
        .SYS_CLK    (clk),
        .RST_N      (rst_n),
        .UP         (up),
        .DOWN       (down),
        .LEFT       (left),
        .RIGHT      (right),
        .PAUSE      (pause),
        .STEP       (step),
        .move_dir   (move_dir),
        .dir_changed(dir_changed),
        .paused     (paused)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic [4:0] b);
        {pause, right, left, down, up} = b;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] b, input int h, input logic s,
                                input logic [1:0] d, input logic c, input logic p);
        vec_t v;
        v.btn = b; v.hold = h; v.stp = s; v.dir = d; v.chg = c; v.p = p;
        return v;
    endfunction

    initial begin
        rst_n = 1'b0;
        step  = 1'b0;
        set_btn(B_NONE);

        // no-input steps and glitch rejection
        vecs.push_back(mk(B_NONE,  0, 1'b1, D_UP,    1'b0, 1'b0));
        vecs.push_back(mk(B_NONE,  0, 1'b1, D_UP,    1'b0, 1'b0));
        vecs.push_back(mk(B_NONE,  0, 1'b1, D_UP,    1'b0, 1'b0));
        vecs.push_back(mk(B_RIGHT, 10, 1'b1, D_RIGHT, 1'b1, 1'b0));
        vecs.push_back(mk(B_RIGHT, 3, 1'b1, D_RIGHT, 1'b0, 1'b0));
        vecs.push_back(mk(B_UP,    3, 1'b1, D_RIGHT, 1'b0, 1'b0));
        vecs.push_back(mk(B_UP,    10, 1'b1, D_UP,    1'b1, 1'b0));
`ifdef DIR_QUEUE2_EN
        // two queued moves, third dropped while full
        vecs.push_back(mk(B_RIGHT, 10, 1'b0, D_UP,    1'b0, 1'b0));
        vecs.push_back(mk(B_DOWN,  10, 1'b0, D_UP,    1'b0, 1'b0));
        vecs.push_back(mk(B_LEFT,  10, 1'b0, D_UP,    1'b0, 1'b0));
        vecs.push_back(mk(B_NONE,  0, 1'b1, D_RIGHT, 1'b1, 1'b0));
        vecs.push_back(mk(B_NONE,  0, 1'b1, D_DOWN,  1'b1, 1'b0));
        vecs.push_back(mk(B_NONE,  0, 1'b1, D_DOWN,  1'b0, 1'b0));
        vecs.push_back(mk(B_UP,    10, 1'b1, D_DOWN,  1'b0, 1'b0));
        // pause toggle flushes a queued move
        vecs.push_back(mk(B_RIGHT, 10, 1'b0, D_DOWN,  1'b0, 1'b0));
        vecs.push_back(mk(B_PAUSE, 10, 1'b0, D_DOWN,  1'b0, 1'b1));
        vecs.push_back(mk(B_PAUSE, 10, 1'b0, D_DOWN,  1'b0, 1'b0));
        vecs.push_back(mk(B_NONE,  0, 1'b1, D_DOWN,  1'b0, 1'b0));
        vecs.push_back(mk(B_PAUSE, 10, 1'b0, D_DOWN,  1'b0, 1'b1));
        vecs.push_back(mk(B_LEFT,  10, 1'b1, D_DOWN,  1'b0, 1'b1));
        vecs.push_back(mk(B_PAUSE, 10, 1'b0, D_DOWN,  1'b0, 1'b0));
        vecs.push_back(mk(B_NONE,  0, 1'b1, D_DOWN,  1'b0, 1'b0));
        vecs.push_back(mk(B_UP | B_LEFT, 10, 1'b1, D_DOWN, 1'b0, 1'b0));
        vecs.push_back(mk(B_LEFT,  10, 1'b1, D_LEFT,  1'b1, 1'b0));
`else
        // reversal rejected, latest accepted request wins
        vecs.push_back(mk(B_LEFT,  10, 1'b0, D_UP,    1'b0, 1'b0));
        vecs.push_back(mk(B_DOWN,  10, 1'b0, D_UP,    1'b0, 1'b0));
        vecs.push_back(mk(B_NONE,  0, 1'b1, D_LEFT,  1'b1, 1'b0));
        vecs.push_back(mk(B_UP,    10, 1'b1, D_UP,    1'b1, 1'b0));
        vecs.push_back(mk(B_LEFT,  10, 1'b0, D_UP,    1'b0, 1'b0));
        vecs.push_back(mk(B_RIGHT, 10, 1'b0, D_UP,    1'b0, 1'b0));
        vecs.push_back(mk(B_NONE,  0, 1'b1, D_RIGHT, 1'b1, 1'b0));
        // pause freezes steps and discards requests
        vecs.push_back(mk(B_PAUSE, 10, 1'b0, D_RIGHT, 1'b0, 1'b1));
        vecs.push_back(mk(B_UP,    10, 1'b1, D_RIGHT, 1'b0, 1'b1));
        vecs.push_back(mk(B_PAUSE, 10, 1'b0, D_RIGHT, 1'b0, 1'b0));
        vecs.push_back(mk(B_NONE,  0, 1'b1, D_RIGHT, 1'b0, 1'b0));
        vecs.push_back(mk(B_UP | B_LEFT, 10, 1'b1, D_RIGHT, 1'b0, 1'b0));
        vecs.push_back(mk(B_DOWN,  10, 1'b1, D_DOWN,  1'b1, 1'b0));
`endif

        repeat (3) tick();
        chk("reset move_dir", 8'(move_dir), 8'(D_UP));
        chk("reset dir_changed", 8'(dir_changed), 8'd0);
        chk("reset paused", 8'(paused), 8'd0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            set_btn(vecs[i].btn);
            repeat (vecs[i].hold) tick();
            set_btn(B_NONE);
            repeat (10) tick();
            step = vecs[i].stp;
            tick();
            step = 1'b0;
            chk($sformatf("v%0d move_dir", i), 8'(move_dir), 8'(vecs[i].dir));
            chk($sformatf("v%0d dir_changed", i), 8'(dir_changed), 8'(vecs[i].chg));
            chk($sformatf("v%0d paused", i), 8'(paused), 8'(vecs[i].p));
            if (vecs[i].chg) begin
                tick();
                chk($sformatf("v%0d pulse_width", i), 8'(dir_changed), 8'd0);
            end
        end

        // asynchronous reset mid-debounce while paused
        set_btn(B_PAUSE);
        repeat (10) tick();
        set_btn(B_NONE);
        repeat (10) tick();
        chk("pre-reset paused", 8'(paused), 8'd1);
        set_btn(B_RIGHT);
        repeat (4) tick();
        rst_n = 1'b0;
        #2;
        chk("async move_dir", 8'(move_dir), 8'(D_UP));
        chk("async dir_changed", 8'(dir_changed), 8'd0);
        chk("async paused", 8'(paused), 8'd0);
        repeat (3) tick();
        rst_n = 1'b1;

        // held button after release still needs a full window
        repeat (2) tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("early step move_dir", 8'(move_dir), 8'(D_UP));
        chk("early step dir_changed", 8'(dir_changed), 8'd0);
        repeat (8) tick();
        set_btn(B_NONE);
        repeat (10) tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("post-reset move_dir", 8'(move_dir), 8'(D_RIGHT));
        chk("post-reset dir_changed", 8'(dir_changed), 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
